// File: rtl/uart_rx.sv
// UART receiver: 8N1 deserializer driven by a 16x oversampling tick.
// Validates the start bit at its midpoint, samples each data bit at mid-bit,
// checks the stop bit and pulses o_rx_done with the received byte.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned SB_TICKS   = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data_byte,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int unsigned TickMax = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
  localparam int unsigned TickW   = (TickMax > 1) ? $clog2(TickMax) : 1;
  localparam int unsigned BitW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] BitLast  = TickW'(OVERSAMPLE - 1);
  localparam logic [TickW-1:0] StopLast = TickW'(SB_TICKS - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rx_meta_q, rx_s_q;

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic; counters only move on oversampling ticks.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        // Start edge is accepted on any clock, not just tick cycles.
        if (!rx_s_q) begin
          state_d    = StStart;
          tick_cnt_d = '0;
        end
      end
      StStart: begin
        if (i_tick) begin
          if (tick_cnt_q == HalfLast) begin
            if (!rx_s_q) begin
              state_d    = StData;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              // Line back high at mid start bit: treat as a glitch.
              state_d = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end
      StData: begin
        if (i_tick) begin
          if (tick_cnt_q == BitLast) begin
            shreg_d    = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == DataLast) begin
              state_d = StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + BitW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end
      StStop: begin
        if (i_tick) begin
          if (tick_cnt_q == StopLast) begin
            data_d  = shreg_q;
            err_d   = ~rx_s_q;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Busy stays up through the done cycle so it falls the cycle after the pulse.
  always_comb begin
    o_busy = (state_q != StIdle) | done_q;
  end

  assign o_data_byte = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the UART_TX transmitter.
- Deserializes an asynchronous 8N1 serial line into parallel bytes, using the 16x oversampling tick from BR_GENERATOR.
- Sits between the external RX pin and the byte consumer.
- Validates the start bit, samples each bit at mid-bit, checks the stop bit, and pulses a done strobe with the received byte.

Parameters:
- DATA_BITS, 8, data bits per frame, sent LSB first.
- OVERSAMPLE, 16, i_tick pulses per bit period; must be even and ≥4.
- SB_TICKS, 16, i_tick pulses from stop-bit start to stop-bit sample point, counted from the mid-bit reference.

Ports:
- i_clock, input, 1: system clock; all logic on posedge.
- i_reset, input, 1: asynchronous, active-low reset.
- i_tick, input, 1: oversampling strobe from BR_GENERATOR; high for one i_clock cycle, OVERSAMPLE per bit.
- i_rx, input, 1: serial line, asynchronous, idle high.
- o_data_byte, output, DATA_BITS: last received byte; held until the next frame completes.
- o_rx_done, output, 1: one-cycle pulse when a frame completes.
- o_frame_err, output, 1: stop bit sampled low on the last frame; valid from o_rx_done and held until the next o_rx_done.
- o_busy, output, 1: high whenever the state is not IDLE.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State goes to IDLE; tick_cnt, bit_cnt and the shift register go to 0.
  - o_data_byte=0, o_rx_done=0, o_frame_err=0, o_busy=0.
  - Both synchronizer flops go to 1 (idle line).
  - Reset mid-frame aborts the frame; no o_rx_done is produced.
- Synchronizer: i_rx passes through 2 flops to give rx_s, a 2-cycle delay. The FSM uses only rx_s.
- IDLE: rx_s==0 on any clock (tick not required) → START, tick_cnt=0.
- START, acting only on cycles with i_tick=1:
  - tick_cnt==OVERSAMPLE/2-1 and rx_s==0 → DATA, tick_cnt=0, bit_cnt=0.
  - tick_cnt==OVERSAMPLE/2-1 and rx_s==1 → IDLE. This rejects a glitch; no outputs change.
  - Otherwise tick_cnt++.
- DATA, on i_tick:
  - tick_cnt==OVERSAMPLE-1 → shift register = {rx_s, shreg[DATA_BITS-1:1]} (right shift, LSB first), tick_cnt=0.
  - Then, if bit_cnt==DATA_BITS-1 → STOP; else bit_cnt++.
  - Otherwise tick_cnt++.
- STOP, on i_tick:
  - tick_cnt==SB_TICKS-1 → o_data_byte=shreg, o_frame_err=~rx_s, o_rx_done=1 for exactly that one cycle, → IDLE.
  - Otherwise tick_cnt++.
- Cycles with i_tick=0 leave all counters unchanged in every state.
- o_rx_done is 0 on every cycle except the completion cycle. o_busy drops on the cycle after o_rx_done.
- On frame error the byte is still delivered; o_frame_err=1 accompanies o_rx_done.
- Line held low after a frame error (break): IDLE immediately re-enters START. A break with all-zero data yields byte 0x00, o_frame_err=1 per frame.
- Back-to-back frames with no idle gap are received without loss: a start edge right after STOP completes is detected in IDLE.
- Nominal latency: o_rx_done occurs (1 + DATA_BITS)·OVERSAMPLE + OVERSAMPLE/2 ticks after the start edge, plus 2-3 clocks.
- Counter widths: tick_cnt is $clog2(max(OVERSAMPLE,SB_TICKS)) bits; bit_cnt is $clog2(DATA_BITS) bits. No wrap occurs in normal operation.

Test Plan:
- Bench setup for all scenarios: i_tick every 4 clocks, so 1 bit = 64 clocks.
- Basic byte: serialize 0xAA 8N1 on i_rx → exactly one o_rx_done pulse, o_data_byte=8'hAA, o_frame_err=0, o_busy high throughout the frame.
- Back-to-back: 0x00, 0xFF, 0x5A with no idle gap → 3 done pulses, bytes 00, FF, 5A in order, no errors.
- Glitch: i_rx low for 12 clocks (3 ticks), then high → returns to IDLE, no o_rx_done, o_data_byte unchanged, o_busy low again within 8 ticks.
- Framing error: 0x3C sent with stop bit 0 → o_rx_done with o_data_byte=8'h3C and o_frame_err=1. A following valid 0x81 clears o_frame_err to 0.
- Reset mid-frame: assert i_reset=0 during data bit 4 of 0xC3 → all outputs 0 immediately (asynchronous). After release, a fresh 0x7E is received correctly and the aborted frame produces no done pulse.
- Baud tolerance: bit period stretched to 67 clocks (~+4.7%) and shrunk to 61 clocks (~-4.7%) for 0x96 → o_data_byte=8'h96, o_frame_err=0 in both cases.
